pushbutton_debouncer: RTL and testbench

PUSHBUTTON_DEBOUNCER -- requirements
Module: pushbutton_debouncer

---
 rtl/pushbutton_debouncer.sv | 134 +++++++++++++
 tb/tb_pushbutton_debouncer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_debouncer.sv
// Four-key pushbutton debouncer: per-key 2-flop synchronizer, STABLE/CHECK
// debounce FSM with a saturating counter, registered press/release pulses and sticky press flags.

module pushbutton_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic clear_edge,
  output logic pushbutton,
  output logic press_pulse,
  output logic release_pulse,
  output logic edge_capture
);
  typedef enum logic {STABLE, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_q, pb_d, pb_prev_q;
  logic             press_q, release_q, ecap_q;

  // Synchronizer resets to the released level so nothing looks pressed out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      pb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_q    <= pb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pb_d    = pb_q;
    unique case (state_q)
      STABLE: begin
        if (s != pb_q) begin
          state_d = CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHECK: begin
        if (s == pb_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          // Counter saturates here: accept the change instead of wrapping.
          pb_d    = ~pb_q;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Pulses follow the debounced level by one cycle; a press pulse beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pb_prev_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      ecap_q    <= 1'b0;
    end else begin
      pb_prev_q <= pb_q;
      press_q   <= pb_q & ~pb_prev_q;
      release_q <= ~pb_q & pb_prev_q;
      ecap_q    <= press_q | (ecap_q & ~clear_edge);
    end
  end

  assign pushbutton    = pb_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign edge_capture  = ecap_q;
endmodule

module pushbutton_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] keys_n,
  input  logic [3:0] clear_edges,
  output logic [3:0] pushbuttons,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic [3:0] edge_capture
);
  localparam int NUM_KEYS = 4;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    pushbutton_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_n        (keys_n[i]),
      .clear_edge   (clear_edges[i]),
      .pushbutton   (pushbuttons[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .edge_capture (edge_capture[i])
    );
  end
endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Directed and randomized bench for pushbutton_debouncer with DEBOUNCE_CYCLES = 4,
// compared every cycle against a sample-history reference model.

module tb_pushbutton_debouncer;
  localparam int D  = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic [3:0] clear_edges = 4'h0;
  logic [3:0] pushbuttons, press_pulse, release_pulse, edge_capture;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]   m_sync1, m_sync2, m_pb, m_pbprev, m_pp, m_rp, m_ec;
  logic [D-1:0] m_hist [4];

  pushbutton_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .keys_n       (keys_n),
    .clear_edges  (clear_edges),
    .pushbuttons  (pushbuttons),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .edge_capture (edge_capture)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 4'hF; m_sync2 = 4'hF;
    m_pb = '0; m_pbprev = '0; m_pp = '0; m_rp = '0; m_ec = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  endtask

  // A key's level flips once its last D synchronized samples all disagree with it.
  task automatic model_edge();
    logic [3:0] s, pb_n;
    s = ~m_sync2;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][D-2:0], s[i]};
      pb_n[i] = (m_hist[i] == {D{~m_pb[i]}}) ? ~m_pb[i] : m_pb[i];
    end
    m_ec     = m_pp | (m_ec & ~clear_edges);
    m_pp     = m_pb & ~m_pbprev;
    m_rp     = ~m_pb & m_pbprev;
    m_pbprev = m_pb;
    m_pb     = pb_n;
    m_sync2  = m_sync1;
    m_sync1  = keys_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_pb", pushbuttons, m_pb);
    chk("model_press", press_pulse, m_pp);
    chk("model_release", release_pulse, m_rp);
    chk("model_ecap", edge_capture, m_ec);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_pb", pushbuttons, 4'h0);
    chk("rst_press", press_pulse, 4'h0);
    chk("rst_release", release_pulse, 4'h0);
    chk("rst_ecap", edge_capture, 4'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [3:0] seen;

  initial begin
    model_reset();
    #12;
    do_reset();

    // Clean press of KEY0
    keys_n = 4'b1110;
    ticks(5);
    chk("clean_pre", pushbuttons, 4'b0000);
    tick();
    chk("clean_pb", pushbuttons, 4'b0001);
    chk("clean_no_early_pulse", press_pulse, 4'b0000);
    tick();
    chk("clean_press", press_pulse, 4'b0001);
    tick();
    chk("clean_press_once", press_pulse, 4'b0000);
    chk("clean_ecap", edge_capture, 4'b0001);
    keys_n = 4'hF;
    ticks(10);

    // Bounce on KEY1 never gets through
    seen = '0;
    keys_n[1] = 1'b0; for (int k = 0; k < 2; k++) begin tick(); seen |= pushbuttons | press_pulse | edge_capture; end
    keys_n[1] = 1'b1; tick(); seen |= pushbuttons | press_pulse | edge_capture;
    keys_n[1] = 1'b0; for (int k = 0; k < 3; k++) begin tick(); seen |= pushbuttons | press_pulse | edge_capture; end
    keys_n[1] = 1'b1; for (int k = 0; k < 10; k++) begin tick(); seen |= pushbuttons | press_pulse | edge_capture; end
    chk("bounce_key1", seen & 4'b0010, 4'b0000);

    // Release of a held KEY2, then clear its flag
    keys_n = 4'b1011;
    ticks(10);
    chk("rel_held", pushbuttons, 4'b0100);
    keys_n[2] = 1'b1;
    ticks(5);
    chk("rel_pre", pushbuttons & 4'b0100, 4'b0100);
    tick();
    chk("rel_pb", pushbuttons & 4'b0100, 4'b0000);
    tick();
    chk("rel_pulse", release_pulse, 4'b0100);
    tick();
    chk("rel_pulse_once", release_pulse, 4'b0000);
    chk("rel_ecap_sticky", edge_capture & 4'b0100, 4'b0100);
    clear_edges = 4'b0100;
    tick();
    chk("clear_ecap2", edge_capture & 4'b0100, 4'b0000);
    clear_edges = 4'h0;

    // Press on KEY3 while its clear is held: set wins
    keys_n = 4'b0111;
    clear_edges = 4'b1000;
    ticks(7);
    chk("coll_press", press_pulse, 4'b1000);
    tick();
    chk("coll_ecap", edge_capture & 4'b1000, 4'b1000);
    clear_edges = 4'hF;
    tick();
    clear_edges = 4'h0;
    keys_n = 4'hF;
    ticks(10);

    // Reset mid-CHECK on KEY0 while KEY1 is held and flags are set
    keys_n = 4'b1101;
    ticks(10);
    keys_n = 4'b1100;
    ticks(4);
    chk("midrst_pre_pb", pushbuttons, 4'b0010);
    do_reset();
    ticks(5);
    chk("midrst_wait", pushbuttons, 4'b0000);
    tick();
    chk("midrst_pb", pushbuttons, 4'b0011);
    keys_n = 4'hF;
    ticks(10);

    // Skewed press of all four keys
    keys_n = 4'b1110; tick();
    keys_n = 4'b1100; tick();
    keys_n = 4'b1000; tick();
    keys_n = 4'b0000;
    ticks(3); chk("skew_k0", pushbuttons, 4'b0001);
    tick();   chk("skew_k1", pushbuttons, 4'b0011);
    tick();   chk("skew_k2", pushbuttons, 4'b0111);
    tick();   chk("skew_k3", pushbuttons, 4'b1111);
    keys_n = 4'b0001; tick();
    keys_n = 4'b0011; tick();
    keys_n = 4'b0111; tick();
    keys_n = 4'b1111;
    ticks(10);
    chk("skew_released", pushbuttons, 4'b0000);

    // Randomized keys, clears and occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) keys_n[i] = ~keys_n[i];
      clear_edges = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
